// File: rtl/vga_timing_param.sv
// -----------------------------------------------------------------------------
// vga_timing_param
//   Parameterised VGA raster timing generator. A horizontal and a vertical
//   counter advance on each pixel strobe. Blanking, sync and start-of-frame
//   are derived from the next counter values and registered together with
//   them, so every output describes the same pixel position.
//
// Optional feature macro: VGA_TIMING_FRAME_CNT_EN
//   When defined, adds a 16-bit frame_cnt output that counts completed frames.
//
// Ports
//   clk       in   pixel clock, all state on rising edge
//   rst       in   asynchronous, active-high reset
//   pix_en    in   pixel strobe; counters advance only when 1
//   hcount    out  [CNT_W] pixel column, 0..H_TOTAL-1
//   vcount    out  [CNT_W] line, 0..V_TOTAL-1
//   hblnk     out  horizontal blanking (active-high)
//   vblnk     out  vertical blanking (active-high)
//   hsync     out  horizontal sync, asserted level HS_POL
//   vsync     out  vertical sync, asserted level VS_POL
//   sof       out  one-cycle start-of-frame pulse
//   frame_cnt out  [16] completed frame count (VGA_TIMING_FRAME_CNT_EN only)
// -----------------------------------------------------------------------------
module vga_timing_param #(
   parameter int unsigned H_ACTIVE = 1024,
   parameter int unsigned H_FP     = 24,
   parameter int unsigned H_SYNC   = 136,
   parameter int unsigned H_BP     = 160,
   parameter int unsigned V_ACTIVE = 768,
   parameter int unsigned V_FP     = 3,
   parameter int unsigned V_SYNC   = 6,
   parameter int unsigned V_BP     = 29,
   parameter bit          HS_POL   = 1'b0,
   parameter bit          VS_POL   = 1'b0,
   parameter int unsigned CNT_W    = 11
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             pix_en,
   output logic [CNT_W-1:0] hcount,
   output logic [CNT_W-1:0] vcount,
   output logic             hblnk,
   output logic             vblnk,
   output logic             hsync,
   output logic             vsync,
   output logic             sof
`ifdef VGA_TIMING_FRAME_CNT_EN
   ,
   output logic [15:0]      frame_cnt
`endif
);

   localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int unsigned HS_BEG  = H_ACTIVE + H_FP;
   localparam int unsigned HS_END  = HS_BEG + H_SYNC;
   localparam int unsigned VS_BEG  = V_ACTIVE + V_FP;
   localparam int unsigned VS_END  = VS_BEG + V_SYNC;

   // Elaboration-time rejection of unusable parameter sets.
   if (H_ACTIVE == 0 || H_FP == 0 || H_SYNC == 0 || H_BP == 0 ||
       V_ACTIVE == 0 || V_FP == 0 || V_SYNC == 0 || V_BP == 0) begin : g_zero_param
      $error("vga_timing_param: active/porch/sync parameters must be non-zero");
   end
   if (CNT_W == 0 || CNT_W > 31 ||
       longint'(H_TOTAL) > (longint'(1) << CNT_W) ||
       longint'(V_TOTAL) > (longint'(1) << CNT_W)) begin : g_width_param
      $error("vga_timing_param: H_TOTAL/V_TOTAL do not fit in CNT_W bits");
   end

   logic             h_last;
   logic             v_last;
   logic             frame_wrap;
   logic [CNT_W-1:0] h_next;
   logic [CNT_W-1:0] v_next;

   always_comb begin
      h_last     = (hcount == CNT_W'(H_TOTAL - 1));
      v_last     = (vcount == CNT_W'(V_TOTAL - 1));
      frame_wrap = h_last && v_last;
      h_next     = hcount + 1'b1;
      v_next     = vcount;
      if (h_last) begin
         h_next = '0;
         v_next = v_last ? '0 : vcount + 1'b1;
      end
   end

   // Decodes use the next counter values so the registered flags line up
   // with the registered counters (no one-pixel skew).
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hcount <= '0;
         vcount <= '0;
         hblnk  <= 1'b0;
         vblnk  <= 1'b0;
         hsync  <= ~HS_POL;
         vsync  <= ~VS_POL;
         sof    <= 1'b0;
      end else begin
         sof <= 1'b0;
         if (pix_en) begin
            hcount <= h_next;
            vcount <= v_next;
            hblnk  <= (h_next >= CNT_W'(H_ACTIVE));
            vblnk  <= (v_next >= CNT_W'(V_ACTIVE));
            hsync  <= ((h_next >= CNT_W'(HS_BEG)) && (h_next < CNT_W'(HS_END))) ? HS_POL
                                                                                 : ~HS_POL;
            vsync  <= ((v_next >= CNT_W'(VS_BEG)) && (v_next < CNT_W'(VS_END))) ? VS_POL
                                                                                 : ~VS_POL;
            // Only a real frame wrap lands on 0,0 here; reset never pulses sof.
            sof    <= frame_wrap;
         end
      end
   end

`ifdef VGA_TIMING_FRAME_CNT_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         frame_cnt <= '0;
      end else if (pix_en && frame_wrap) begin
         frame_cnt <= frame_cnt + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_vga_timing_param.sv
// -----------------------------------------------------------------------------
// tb_vga_timing_param
//   Self-checking bench. Instance s_dut uses a small raster
//   (H 8/2/2/2, V 4/1/1/1, positive syncs: 14 x 7 = 98 pixels per frame);
//   instance d_dut uses the default 1344 x 806 raster and is checked across
//   its first line. Both share clock, reset and pixel strobe.
// -----------------------------------------------------------------------------
module tb_vga_timing_param;

   logic        clk = 1'b0;
   logic        rst;
   logic        pix_en;

   logic [10:0] s_h, s_v, d_h, d_v;
   logic        s_hblnk, s_vblnk, s_hsync, s_vsync, s_sof;
   logic        d_hblnk, d_vblnk, d_hsync, d_vsync, d_sof;
`ifdef VGA_TIMING_FRAME_CNT_EN
   logic [15:0] s_fc, d_fc;
`endif

   always #5 clk = ~clk;

   vga_timing_param #(
      .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
      .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
      .HS_POL(1'b1), .VS_POL(1'b1), .CNT_W(11)
   ) s_dut (
      .clk   (clk),
      .rst   (rst),
      .pix_en(pix_en),
      .hcount(s_h),
      .vcount(s_v),
      .hblnk (s_hblnk),
      .vblnk (s_vblnk),
      .hsync (s_hsync),
      .vsync (s_vsync),
      .sof   (s_sof)
`ifdef VGA_TIMING_FRAME_CNT_EN
      ,
      .frame_cnt(s_fc)
`endif
   );

   vga_timing_param d_dut (
      .clk   (clk),
      .rst   (rst),
      .pix_en(pix_en),
      .hcount(d_h),
      .vcount(d_v),
      .hblnk (d_hblnk),
      .vblnk (d_vblnk),
      .hsync (d_hsync),
      .vsync (d_vsync),
      .sof   (d_sof)
`ifdef VGA_TIMING_FRAME_CNT_EN
      ,
      .frame_cnt(d_fc)
`endif
   );

   int n_tests = 0;
   int n_fail  = 0;

   // Expected raster positions and frame counts.
   int sh, sv, dh, dv;
   int s_frames, d_frames;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic check_reset();
      check_eq("rst_s_hcount", 32'(s_h), 32'd0);
      check_eq("rst_s_vcount", 32'(s_v), 32'd0);
      check_eq("rst_s_hblnk", 32'(s_hblnk), 32'd0);
      check_eq("rst_s_vblnk", 32'(s_vblnk), 32'd0);
      check_eq("rst_s_hsync", 32'(s_hsync), 32'd0);
      check_eq("rst_s_vsync", 32'(s_vsync), 32'd0);
      check_eq("rst_s_sof", 32'(s_sof), 32'd0);
      check_eq("rst_d_hcount", 32'(d_h), 32'd0);
      check_eq("rst_d_vcount", 32'(d_v), 32'd0);
      check_eq("rst_d_hblnk", 32'(d_hblnk), 32'd0);
      check_eq("rst_d_vblnk", 32'(d_vblnk), 32'd0);
      check_eq("rst_d_hsync", 32'(d_hsync), 32'd1);
      check_eq("rst_d_vsync", 32'(d_vsync), 32'd1);
      check_eq("rst_d_sof", 32'(d_sof), 32'd0);
`ifdef VGA_TIMING_FRAME_CNT_EN
      check_eq("rst_s_frame_cnt", 32'(s_fc), 32'd0);
      check_eq("rst_d_frame_cnt", 32'(d_fc), 32'd0);
`endif
   endtask

   task automatic model_clear();
      sh = 0; sv = 0; dh = 0; dv = 0;
      s_frames = 0; d_frames = 0;
   endtask

   // One clock with the given strobe, then compare both instances.
   task automatic tick(input logic en);
      bit s_exp_sof, d_exp_sof;
      pix_en = en;
      @(posedge clk);
      #1;
      s_exp_sof = en && (sh == 13) && (sv == 6);
      d_exp_sof = en && (dh == 1343) && (dv == 805);
      if (en) begin
         if (sh == 13) begin sh = 0; sv = (sv == 6) ? 0 : sv + 1; end
         else sh++;
         if (dh == 1343) begin dh = 0; dv = (dv == 805) ? 0 : dv + 1; end
         else dh++;
      end
      if (s_exp_sof) s_frames = (s_frames + 1) % 65536;
      if (d_exp_sof) d_frames = (d_frames + 1) % 65536;

      // Small raster: hblnk 8..13, hsync high 10..11, vblnk 4..6, vsync high at 5.
      check_eq("s_hcount", 32'(s_h), 32'(sh));
      check_eq("s_vcount", 32'(s_v), 32'(sv));
      check_eq("s_hblnk", 32'(s_hblnk), 32'(sh >= 8));
      check_eq("s_vblnk", 32'(s_vblnk), 32'(sv >= 4));
      check_eq("s_hsync", 32'(s_hsync), 32'(sh == 10 || sh == 11));
      check_eq("s_vsync", 32'(s_vsync), 32'(sv == 5));
      check_eq("s_sof", 32'(s_sof), 32'(s_exp_sof));
      // Default raster: hsync low 1048..1183, vsync low 771..776.
      check_eq("d_hcount", 32'(d_h), 32'(dh));
      check_eq("d_vcount", 32'(d_v), 32'(dv));
      check_eq("d_hblnk", 32'(d_hblnk), 32'(dh >= 1024));
      check_eq("d_vblnk", 32'(d_vblnk), 32'(dv >= 768));
      check_eq("d_hsync", 32'(d_hsync), 32'(!(dh >= 1048 && dh < 1184)));
      check_eq("d_vsync", 32'(d_vsync), 32'(!(dv >= 771 && dv < 777)));
      check_eq("d_sof", 32'(d_sof), 32'(d_exp_sof));
`ifdef VGA_TIMING_FRAME_CNT_EN
      check_eq("s_frame_cnt", 32'(s_fc), 32'(s_frames));
      check_eq("d_frame_cnt", 32'(d_fc), 32'(d_frames));
`endif
   endtask

   initial begin
      int sof_cnt, first_sof, hb_rise, hs_low;

      // Reset with strobe off and clocks running.
      rst    = 1'b1;
      pix_en = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_reset();
      rst = 1'b0;
      model_clear();

      // Continuous strobe: 1400 pixels = 14 small frames, full first default line.
      sof_cnt = 0; first_sof = -1; hb_rise = -1; hs_low = 0;
      for (int i = 1; i <= 1400; i++) begin
         tick(1'b1);
         if (s_sof === 1'b1) begin
            sof_cnt++;
            if (first_sof < 0) first_sof = i;
         end
         if (d_v == 11'd0 && d_hsync === 1'b0) hs_low++;
         if (hb_rise < 0 && d_hblnk === 1'b1) hb_rise = int'(d_h);
      end
      check_eq("s_sof_count_cont", 32'(sof_cnt), 32'd14);
      check_eq("s_sof_first_cycle", 32'(first_sof), 32'd98);
      check_eq("d_hblnk_rise_col", 32'(hb_rise), 32'd1024);
      check_eq("d_hsync_low_len", 32'(hs_low), 32'd136);

      // Strobe 1,0,1,0: 196 clocks = 98 pixels = exactly one small frame.
      sof_cnt = 0;
      for (int i = 0; i < 196; i++) begin
         tick((i % 2) == 0);
         if (s_sof === 1'b1) sof_cnt++;
      end
      check_eq("s_sof_count_toggle", 32'(sof_cnt), 32'd1);

      // Move mid-frame, then assert reset away from any clock edge.
      for (int i = 0; i < 40; i++) tick(1'b1);
      @(posedge clk);
      #3;
      rst = 1'b1;
      #1;
      check_reset();
      @(posedge clk);
      #1;
      check_reset();
      rst = 1'b0;
      model_clear();

      // Restart from 0,0: first sof only after a full 98-pixel frame.
      sof_cnt = 0; first_sof = -1;
      for (int i = 1; i <= 300; i++) begin
         tick(1'b1);
         if (s_sof === 1'b1) begin
            sof_cnt++;
            if (first_sof < 0) first_sof = i;
         end
      end
      check_eq("s_sof_count_after_rst", 32'(sof_cnt), 32'd3);
      check_eq("s_sof_first_after_rst", 32'(first_sof), 32'd98);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/vga_timing_param.md
VGA_TIMING_PARAM -- requirements
Module: vga_timing_param

Interface
REQ-001 SHALL have parameter H_ACTIVE, 1024, visible pixels per line.
REQ-002 SHALL have parameter H_FP, 24, horizontal front porch in pixels.
REQ-003 SHALL have parameter H_SYNC, 136, horizontal sync width in pixels.
REQ-004 SHALL have parameter H_BP, 160, horizontal back porch in pixels.
REQ-005 SHALL have parameters V_ACTIVE 768, V_FP 3, V_SYNC 6, V_BP 29: vertical equivalents, in lines.
REQ-006 SHALL have parameter HS_POL, 0, hsync asserted level (0 = active-low).
REQ-007 SHALL have parameter VS_POL, 0, vsync asserted level.
REQ-008 SHALL have parameter CNT_W, 11, width of hcount/vcount.
REQ-009 SHALL have port clk  input  1  pixel clock, all state on its rising edge.
REQ-010 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-011 SHALL have port pix_en  input  1  pixel strobe; counters advance only in cycles where it is 1.
REQ-012 SHALL have port hcount  output  CNT_W  current pixel column, 0..H_TOTAL-1.
REQ-013 SHALL have port vcount  output  CNT_W  current line, 0..V_TOTAL-1.
REQ-014 SHALL have ports hblnk, vblnk  output  1 each  horizontal/vertical blanking (active-high).
REQ-015 SHALL have ports hsync, vsync  output  1 each  sync, polarity per HS_POL/VS_POL.
REQ-016 SHALL have port sof  output  1  one-cycle start-of-frame pulse.

Function
REQ-017 SHALL define H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (1344) and V_TOTAL likewise (806).
REQ-018 SHALL increment hcount by 1 per cycle with pix_en=1; at H_TOTAL-1 it SHALL wrap to 0 and vcount SHALL increment in the same cycle.
REQ-019 SHALL wrap vcount from V_TOTAL-1 to 0 when hcount wraps at H_TOTAL-1; both counters reach 0 in the same cycle.
REQ-020 SHALL hold all outputs unchanged in cycles with pix_en=0 (except sof, which SHALL be 0).
REQ-021 SHALL register all outputs; hblnk/hsync/vblnk/vsync SHALL be aligned with the hcount/vcount values presented in the same cycle (no skew).
REQ-022 SHALL assert hblnk iff hcount >= H_ACTIVE; vblnk iff vcount >= V_ACTIVE.
REQ-023 SHALL assert hsync iff H_ACTIVE+H_FP <= hcount < H_ACTIVE+H_FP+H_SYNC (1048..1183 by default); vsync iff V_ACTIVE+V_FP <= vcount < V_ACTIVE+V_FP+V_SYNC (771..776); asserted = HS_POL/VS_POL level.
REQ-024 SHALL pulse sof for exactly one clock in the cycle hcount=0 and vcount=0 become valid after a frame wrap (not after reset).
REQ-025 SHALL reject at elaboration any parameter set where H_TOTAL or V_TOTAL exceeds 2**CNT_W or any porch/sync/active value is 0.

Reset
REQ-026 SHALL, while rst=1, drive hcount=0, vcount=0, hblnk=0, vblnk=0, sof=0, hsync=!HS_POL, vsync=!VS_POL, regardless of clk.
REQ-027 SHALL resume counting from 0,0 on the first pix_en=1 edge after rst deasserts; reset mid-line or mid-frame SHALL discard position with no partial sof.

Configuration
REQ-028 SHALL, with VGA_TIMING_FRAME_CNT_EN defined, add port frame_cnt  output  16  count of completed frames, reset 0, incremented in the sof cycle, wrapping 0xFFFF->0.
REQ-029 SHALL, without VGA_TIMING_FRAME_CNT_EN, omit frame_cnt port and its logic entirely; all other behaviour identical.

Verification
REQ-030 Defaults, pix_en=1, reset then run 1 frame -> hcount 0..1343, vcount 0..805, sof period 1,083,264 cycles.
REQ-031 Defaults, probe line 0 -> hblnk rises at hcount=1024, hsync low for hcount 1048..1183 (136 cycles), vsync low only for vcount 771..776.
REQ-032 pix_en toggled 1,0,1,0 -> counters advance every second cycle, frame takes 2,166,528 cycles, outputs stable when pix_en=0.
REQ-033 rst pulsed asynchronously at hcount=500, vcount=300 -> outputs go to reset values before the next edge; counting restarts at 0,0; no sof.
REQ-034 Small config H 8/2/2/2, V 4/1/1/1, HS_POL=VS_POL=1 -> H_TOTAL 14, hsync high at hcount 10..11, vsync high at vcount 5, sof every 98 cycles.
REQ-035 With VGA_TIMING_FRAME_CNT_EN and small config, run 3 frames -> frame_cnt = 1,2,3 updating in each sof cycle.
